// File: rtl/memory_arbiter_if.sv
// rtl/memory_arbiter_if.sv - requester, RAM and status signals of the memory arbiter
interface memory_arbiter_if;
  logic        iREN;
  logic [31:0] iaddr;
  logic [31:0] iload;
  logic        iwait;
  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic [31:0] dload;
  logic        dwait;
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload;
  logic [1:0]  ramstate;
  logic        err;
  logic        dgrant;

  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    output iload, iwait, dload, dwait, ramREN, ramWEN, ramaddr, ramstore, err, dgrant
  );

  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    input  iload, iwait, dload, dwait, ramREN, ramWEN, ramaddr, ramstore, err, dgrant
  );
endinterface

// File: rtl/memory_arbiter.sv
// rtl/memory_arbiter.sv - single-port RAM arbiter between fetch and data paths
module memory_arbiter #(
  parameter int STARVE_MAX = 4,
  parameter int TIMEOUT    = 255,
  parameter int CNT_W      = 8
) (
  input  logic            CLK,
  input  logic            RST,
  memory_arbiter_if.slave bus
);
  localparam int         SW         = $clog2(STARVE_MAX + 1);
  localparam logic [1:0] RAM_ACCESS = 2'd2;
  localparam logic [1:0] RAM_ERROR  = 2'd3;

  typedef enum logic [1:0] {IDLE, DACC, IACC, ERR} state_t;

  state_t           state, state_n;
  logic [SW-1:0]    starve_cnt, starve_n;
  logic [CNT_W-1:0] tmo_cnt, tmo_n;
  logic [31:0]      lat_addr, addr_n;
  logic [31:0]      lat_data, data_n;
  logic             lat_write, write_n;

  logic in_acc, access, dreq, grant_d;

  assign in_acc  = (state == DACC) || (state == IACC);
  assign access  = (bus.ramstate == RAM_ACCESS);
  assign dreq    = bus.dREN | bus.dWEN;
  // Data wins unless fetch has already been passed over STARVE_MAX times in a row.
  assign grant_d = dreq && ((starve_cnt < SW'(STARVE_MAX)) || !bus.iREN);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      starve_cnt <= '0;
      tmo_cnt    <= '0;
      lat_addr   <= '0;
      lat_data   <= '0;
      lat_write  <= 1'b0;
    end else begin
      state      <= state_n;
      starve_cnt <= starve_n;
      tmo_cnt    <= tmo_n;
      lat_addr   <= addr_n;
      lat_data   <= data_n;
      lat_write  <= write_n;
    end
  end

  always_comb begin
    state_n  = state;
    starve_n = starve_cnt;
    tmo_n    = tmo_cnt;
    addr_n   = lat_addr;
    data_n   = lat_data;
    write_n  = lat_write;
    unique case (state)
      IDLE: begin
        if (grant_d) begin
          state_n = DACC;
          addr_n  = bus.daddr;
          data_n  = bus.dstore;
          write_n = bus.dWEN;
          tmo_n   = '0;
          if (bus.iREN)
            starve_n = (starve_cnt == SW'(STARVE_MAX)) ? starve_cnt : starve_cnt + 1'b1;
          else
            starve_n = '0;
        end else if (bus.iREN) begin
          state_n  = IACC;
          addr_n   = bus.iaddr;
          data_n   = '0;
          write_n  = 1'b0;
          tmo_n    = '0;
          starve_n = '0;
        end
      end
      DACC, IACC: begin
        // Completion takes priority over a timeout landing in the same cycle.
        if (access) begin
          state_n = IDLE;
          tmo_n   = '0;
        end else if ((bus.ramstate == RAM_ERROR) || (tmo_cnt == CNT_W'(TIMEOUT))) begin
          state_n = ERR;
        end else begin
          tmo_n = tmo_cnt + 1'b1;
        end
      end
      default: begin
      end
    endcase
  end

  assign bus.ramREN   = (state == IACC) || ((state == DACC) && !lat_write);
  assign bus.ramWEN   = (state == DACC) && lat_write;
  assign bus.ramaddr  = in_acc ? lat_addr : '0;
  assign bus.ramstore = (state == DACC) ? lat_data : '0;
  assign bus.dgrant   = (state == DACC);
  assign bus.err      = (state == ERR);
  assign bus.iload    = ((state == IACC) && access) ? bus.ramload : '0;
  assign bus.dload    = ((state == DACC) && access) ? bus.ramload : '0;
  assign bus.iwait    = bus.iREN & !((state == IACC) && access);
  assign bus.dwait    = dreq & !((state == DACC) && access);
endmodule

// File: tb/tb_memory_arbiter.sv
// tb/tb_memory_arbiter.sv - directed and randomized scoreboard bench for memory_arbiter
module tb_memory_arbiter;
  localparam int         STARVE_MAX = 4;
  localparam int         TIMEOUT    = 255;
  localparam logic [1:0] FREE   = 2'd0;
  localparam logic [1:0] BUSY   = 2'd1;
  localparam logic [1:0] ACCESS = 2'd2;
  localparam logic [1:0] ERROR  = 2'd3;

  typedef struct {
    bit          w;
    logic [31:0] addr;
    logic [31:0] val;
  } exp_t;

  logic CLK = 1'b0;
  logic RST;
  memory_arbiter_if bus();

  memory_arbiter #(.STARVE_MAX(STARVE_MAX), .TIMEOUT(TIMEOUT), .CNT_W(8)) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  always #5 CLK = ~CLK;

  int   checks = 0;
  int   errors = 0;
  bit   rand_mode = 0;
  bit   d_done = 0, i_done = 0;
  bit   d_active = 0, i_active = 0;
  exp_t exp_d[$];
  exp_t exp_i[$];
  logic [31:0] dref [16];
  logic [31:0] ram_mem [16];
  int   ram_lat = -1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, want);
    end
  endtask

  function automatic logic [31:0] ifunc(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'hA5A5_0000;
  endfunction

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    bus.iREN = 0; bus.iaddr = 0; bus.dREN = 0; bus.dWEN = 0;
    bus.daddr = 0; bus.dstore = 0; bus.ramload = 0; bus.ramstate = FREE;
  endtask

  task automatic do_reset();
    step();
    RST = 1;
    idle_inputs();
    step();
    step();
    RST = 0;
  endtask

  task automatic issue_data();
    bit w;
    logic [31:0] a, v;
    w = 1'($urandom_range(0, 1));
    a = 32'h1000 + 32'(4 * $urandom_range(0, 15));
    if (w) begin
      v = $urandom;
      dref[a[5:2]] = v;
      bus.dWEN = 1; bus.dREN = 1'($urandom_range(0, 1)); bus.dstore = v;
    end else begin
      v = dref[a[5:2]];
      bus.dWEN = 0; bus.dREN = 1; bus.dstore = $urandom;
    end
    bus.daddr = a;
    exp_d.push_back('{w, a, v});
    d_active = 1;
  endtask

  task automatic issue_fetch();
    logic [31:0] a;
    a = 32'(4 * $urandom_range(0, 255));
    bus.iREN = 1; bus.iaddr = a;
    exp_i.push_back('{1'b0, a, ifunc(a)});
    i_active = 1;
  endtask

  // RAM model: random 0..4 BUSY cycles before ACCESS; data region 0x1000.. backed by ram_mem.
  initial begin : ram_model
    forever begin
      step();
      if (rand_mode) begin
        if (bus.ramREN | bus.ramWEN) begin
          if (ram_lat < 0) ram_lat = $urandom_range(0, 4);
          else ram_lat = ram_lat - 1;
          bus.ramstate = (ram_lat == 0) ? ACCESS : BUSY;
        end else begin
          ram_lat = -1;
          bus.ramstate = FREE;
        end
        if (bus.ramstate == ACCESS)
          bus.ramload = bus.ramaddr[12] ? ram_mem[bus.ramaddr[5:2]] : ifunc(bus.ramaddr);
        else
          bus.ramload = $urandom;
      end
    end
  end

  always @(negedge CLK) begin
    if (rand_mode && bus.ramstate == ACCESS && bus.ramWEN && bus.ramaddr[12])
      ram_mem[bus.ramaddr[5:2]] <= bus.ramstore;
  end

  // Monitor: pops the scoreboard on every completion and checks the grant order.
  logic prev_en = 0, prev_i = 0, prev_d = 0;
  int   streak = 0;
  always @(negedge CLK) begin
    logic en;
    bit   want_d;
    exp_t e;
    en = bus.ramREN | bus.ramWEN;
    if (RST) streak = 0;
    if (rand_mode) begin
      if (bus.iREN && !bus.iwait) begin
        if (exp_i.size() == 0) begin
          checks++; errors++;
          $display("FAIL fetch_unexpected: completion at 0x%08h with empty queue", bus.ramaddr);
        end else begin
          e = exp_i.pop_front();
          check("fetch_addr", bus.ramaddr, e.addr);
          check("fetch_data", bus.iload, e.val);
        end
        i_done = 1;
      end
      if ((bus.dREN | bus.dWEN) && !bus.dwait) begin
        if (exp_d.size() == 0) begin
          checks++; errors++;
          $display("FAIL data_unexpected: completion at 0x%08h with empty queue", bus.ramaddr);
        end else begin
          e = exp_d.pop_front();
          check("data_addr", bus.ramaddr, e.addr);
          check("data_is_write", bus.ramWEN, 32'(e.w));
          if (e.w) check("data_store", bus.ramstore, e.val);
          else     check("data_load", bus.dload, e.val);
        end
        d_done = 1;
      end
      if (bus.ramstate != ACCESS) check("load_idle_zero", bus.iload | bus.dload, 0);
      check("no_err", bus.err, 0);
      if (en && !prev_en) begin
        want_d = prev_d && (streak < STARVE_MAX || !prev_i);
        check("grant_owner", bus.dgrant, 32'(want_d));
        if (want_d && prev_i) streak = (streak < STARVE_MAX) ? streak + 1 : streak;
        else streak = 0;
      end
      if (!prev_en && (prev_i || prev_d)) check("grant_taken", en, 1);
    end
    prev_en = en;
    prev_i  = bus.iREN;
    prev_d  = bus.dREN | bus.dWEN;
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : main
    bit seq [10];
    int gi, busy_cycles;
    bit got_err;
    RST = 1;
    idle_inputs();
    for (int k = 0; k < 16; k++) begin
      dref[k] = $urandom;
      ram_mem[k] = dref[k];
    end
    repeat (2) @(posedge CLK);
    #1 RST = 0;

    @(negedge CLK);
    check("reset_flags", {bus.iwait, bus.dwait, bus.ramREN, bus.ramWEN, bus.err, bus.dgrant}, 0);
    check("reset_buses", bus.ramaddr | bus.ramstore | bus.iload | bus.dload, 0);

    // Fetch only, ACCESS on the 3rd access cycle
    step(); bus.iREN = 1; bus.iaddr = 32'h40;
    @(negedge CLK); check("fetch_idle_ren", bus.ramREN, 0); check("fetch_idle_iwait", bus.iwait, 1);
    step(); bus.ramstate = BUSY;
    @(negedge CLK); check("fetch_ren", bus.ramREN, 1); check("fetch_ramaddr", bus.ramaddr, 32'h40);
    check("fetch_busy_iwait", bus.iwait, 1);
    step();
    step(); bus.ramstate = ACCESS; bus.ramload = 32'h8C220004;
    @(negedge CLK); check("fetch_done_iwait", bus.iwait, 0); check("fetch_iload", bus.iload, 32'h8C220004);
    step(); bus.iREN = 0; bus.ramstate = FREE; bus.ramload = 0;
    @(negedge CLK); check("fetch_after_ren", bus.ramREN, 0); check("fetch_after_iload", bus.iload, 0);

    // Collision: data first, fetch on the following IDLE
    step(); bus.iREN = 1; bus.iaddr = 32'h80; bus.dWEN = 1; bus.daddr = 32'h100; bus.dstore = 32'hDEADBEEF;
    @(negedge CLK); check("coll_idle_dgrant", bus.dgrant, 0); check("coll_idle_wen", bus.ramWEN, 0);
    step(); bus.ramstate = ACCESS; bus.ramload = 32'h11111111;
    @(negedge CLK);
    check("coll_wen", bus.ramWEN, 1); check("coll_ren", bus.ramREN, 0);
    check("coll_store", bus.ramstore, 32'hDEADBEEF); check("coll_addr", bus.ramaddr, 32'h100);
    check("coll_dgrant", bus.dgrant, 1); check("coll_dwait", bus.dwait, 0); check("coll_iwait", bus.iwait, 1);
    step(); bus.dWEN = 0; bus.ramstate = FREE;
    @(negedge CLK); check("coll_gap_en", bus.ramREN | bus.ramWEN, 0);
    step(); bus.ramstate = ACCESS; bus.ramload = 32'h22222222;
    @(negedge CLK);
    check("coll_fetch_ren", bus.ramREN, 1); check("coll_fetch_addr", bus.ramaddr, 32'h80);
    check("coll_fetch_store", bus.ramstore, 0); check("coll_fetch_dgrant", bus.dgrant, 0);
    check("coll_fetch_iload", bus.iload, 32'h22222222);
    step(); bus.iREN = 0; bus.ramstate = FREE;

    // Reset in the middle of a data access
    step(); bus.dREN = 1; bus.daddr = 32'h200;
    step(); bus.ramstate = BUSY;
    @(negedge CLK); check("rstmid_ren", bus.ramREN, 1);
    step(); RST = 1;
    step();
    @(negedge CLK); check("rstmid_en", bus.ramREN | bus.ramWEN, 0); check("rstmid_dgrant", bus.dgrant, 0);
    step(); RST = 0; bus.dREN = 0; bus.ramstate = FREE;

    // Starvation: fetch and data both held high, RAM answers at once
    step(); bus.iREN = 1; bus.iaddr = 32'h60; bus.dREN = 1; bus.daddr = 32'h1000;
    gi = 0;
    for (int c = 0; c < 40 && gi < 10; c++) begin
      @(negedge CLK);
      if (bus.ramREN | bus.ramWEN) begin
        seq[gi] = bus.dgrant;
        gi++;
      end
      step();
      bus.ramstate = (bus.ramREN | bus.ramWEN) ? ACCESS : FREE;
    end
    check("starve_grants", gi, 10);
    for (int k = 0; k < 10; k++) check("starve_owner", 32'(seq[k]), (k % 5 == 4) ? 0 : 1);
    do_reset();

    // Timeout with RAM stuck BUSY
    step(); bus.dREN = 1; bus.daddr = 32'h300;
    step(); bus.ramstate = BUSY;
    busy_cycles = 0;
    got_err = 0;
    for (int c = 0; c < 400; c++) begin
      @(negedge CLK);
      if (bus.err) begin
        got_err = 1;
        break;
      end
      if (bus.ramREN) busy_cycles++;
    end
    check("tmo_err", 32'(got_err), 1);
    checks++;
    if (busy_cycles != TIMEOUT && busy_cycles != TIMEOUT + 1) begin
      errors++;
      $display("FAIL tmo_cycles: got %0d access cycles, expected %0d or %0d", busy_cycles, TIMEOUT, TIMEOUT + 1);
    end
    check("tmo_en", bus.ramREN | bus.ramWEN, 0);
    check("tmo_dwait", bus.dwait, 1);
    step(); bus.ramstate = FREE;
    repeat (4) @(negedge CLK);
    check("tmo_sticky_err", bus.err, 1); check("tmo_sticky_dwait", bus.dwait, 1);
    do_reset();
    @(negedge CLK); check("tmo_cleared", bus.err, 0);

    // RAM ERROR during a fetch
    step(); bus.iREN = 1; bus.iaddr = 32'h44;
    step(); bus.ramstate = BUSY;
    @(negedge CLK); check("ramerr_ren", bus.ramREN, 1);
    step(); bus.ramstate = ERROR;
    @(negedge CLK); check("ramerr_not_yet", bus.err, 0);
    step(); bus.ramstate = FREE;
    @(negedge CLK); check("ramerr_err", bus.err, 1); check("ramerr_en", bus.ramREN, 0);
    check("ramerr_iwait", bus.iwait, 1);
    do_reset();

    // Request dropped mid-access still completes
    step(); bus.dREN = 1; bus.daddr = 32'h500;
    step(); bus.ramstate = BUSY; bus.dREN = 0;
    @(negedge CLK); check("drop_ren", bus.ramREN, 1); check("drop_addr", bus.ramaddr, 32'h500);
    step(); bus.ramstate = ACCESS; bus.ramload = 32'h5A5A5A5A;
    @(negedge CLK); check("drop_dload", bus.dload, 32'h5A5A5A5A);
    step(); bus.ramstate = FREE;
    @(negedge CLK); check("drop_idle1", bus.ramREN | bus.ramWEN, 0);
    step();
    @(negedge CLK); check("drop_idle2", bus.ramREN | bus.ramWEN, 0);

    // Randomized traffic against the scoreboard
    do_reset();
    rand_mode = 1;
    for (int c = 0; c < 3000; c++) begin
      step();
      if (d_done) begin
        d_done = 0; d_active = 0; bus.dREN = 0; bus.dWEN = 0;
      end
      if (i_done) begin
        i_done = 0; i_active = 0; bus.iREN = 0;
      end
      if (!d_active && c < 2800 && $urandom_range(0, 2) != 0) issue_data();
      if (!i_active && c < 2800 && $urandom_range(0, 2) != 0) issue_fetch();
    end
    check("sb_data_empty", exp_d.size(), 0);
    check("sb_fetch_empty", exp_i.size(), 0);
    check("sb_idle", {30'd0, d_active, i_active}, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
